bram_diff_serial_host: RTL and testbench

- Host-side driver for the bram_diff minitest serial harness, which uses a single-wire serial input (di), a load strobe (stb) and a single-wire serial output (do).
- Accepts a parallel stimulus word through a valid/ready handshake and shifts it out MSB-first on di.
- Pulses stb so the DUT latches the word into its parallel input register and loads its parallel result into its output shift register.
- Shifts the result back in from do and presents it as a parallel word through a valid/ready handshake.
- Intended for simulation benches and for on-board self-test wrappers around the minitest tops.

---
 rtl/bram_diff_pkg.sv | 30 +++
 rtl/bram_diff_shreg.sv | 48 ++++
 rtl/bram_diff_serial_host.sv | 150 +++++++++++++++
 tb/tb_bram_diff_serial_host.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_diff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_diff_pkg
// Description : Shared constants, FSM state encoding and helper for the
//               bram_diff serial host.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_diff_pkg;

    // Default word widths of the bram_diff minitest harness
    localparam int DIN_N_DEFAULT  = 8;
    localparam int DOUT_N_DEFAULT = 8;

    // Host FSM state encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_SHIFT   = 3'd1;
    localparam state_t c_ST_STROBE  = 3'd2;
    localparam state_t c_ST_CAPTURE = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

    // Larger of two integers, used to size the shared bit counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_diff_shreg.sv
`default_nettype none
// ============================================================================
// Module      : bram_diff_shreg
// Description : Shift register with synchronous parallel load, serial input
//               at the LSB and serial output from the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_diff_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_q,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    // Next value for a left shift; a 1-bit register simply takes the input
    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = i_ser_in;
        end else begin : g_wide
            assign w_shifted = {r_q[WIDTH-2:0], i_ser_in};
        end
    endgenerate

    // Register update: reset, then parallel load, then shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= w_shifted;
        end
    end

    assign o_q       = r_q;
    assign o_ser_out = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/bram_diff_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : bram_diff_serial_host
// Description : Host driver for the bram_diff serial harness. Shifts a
//               parallel stimulus word out on di (MSB first), strobes stb for
//               one cycle, then shifts the DUT result back in from dut_do and
//               offers it through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_diff_serial_host
    import bram_diff_pkg::*;
#(
    parameter int DIN_N  = DIN_N_DEFAULT,
    parameter int DOUT_N = DOUT_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_N-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_N-1:0] out_data,
    output logic              di,
    output logic              stb,
    input  logic              dut_do,
    output logic              busy
);

    // Counter sized to hold the larger of the two word widths
    localparam int CNT_W = $clog2(max_int(DIN_N, DOUT_N) + 1);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_DIN  = CNT_W'(DIN_N);
    localparam logic [CNT_W-1:0] c_CNT_DOUT = CNT_W'(DOUT_N);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_di;
    logic               r_stb;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_tx_ser_out;
    logic [DIN_N-1:0]   w_tx_q;
    logic [DIN_N-1:0]   w_tx_load_data;
    logic [DOUT_N-1:0]  w_rx_q;
    logic               w_rx_ser_out;
    logic               w_unused;

    assign in_ready = (r_state == c_ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // The MSB goes straight to di on the accept edge, so the tx register is
    // preloaded with the remaining bits already moved up by one position.
    assign w_tx_load_data = in_data << 1;

    bram_diff_shreg #(
        .WIDTH (DIN_N)
    ) u_tx_shreg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_data (w_tx_load_data),
        .i_shift_en  (r_state == c_ST_SHIFT),
        .i_ser_in    (1'b0),
        .o_q         (w_tx_q),
        .o_ser_out   (w_tx_ser_out)
    );

    // The rx register is cleared on accept so it never carries stale bits
    bram_diff_shreg #(
        .WIDTH (DOUT_N)
    ) u_rx_shreg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_data ({DOUT_N{1'b0}}),
        .i_shift_en  (r_state == c_ST_CAPTURE),
        .i_ser_in    (dut_do),
        .o_q         (w_rx_q),
        .o_ser_out   (w_rx_ser_out)
    );

    // Only the tx serial output and rx parallel output carry information
    assign w_unused = &{1'b0, w_tx_q, w_rx_ser_out};

    // Transaction sequencer: shift out, strobe, capture, hand off
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_di        <= 1'b0;
            r_stb       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_SHIFT;
                        r_cnt   <= c_CNT_DIN;
                        r_di    <= in_data[DIN_N-1];
                    end
                end
                c_ST_SHIFT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ST_STROBE;
                        r_stb   <= 1'b1;
                        r_di    <= 1'b0;
                    end else begin
                        r_di    <= w_tx_ser_out;
                    end
                end
                c_ST_STROBE: begin
                    r_stb   <= 1'b0;
                    r_cnt   <= c_CNT_DOUT;
                    r_state <= c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_di        <= 1'b0;
                    r_stb       <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign di        = r_di;
    assign stb       = r_stb;
    assign out_valid = r_out_valid;
    assign out_data  = w_rx_q;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bram_diff_serial_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bram_diff_serial_host
// Description : Self-checking bench for bram_diff_serial_host with behavioural
//               models of the bram_diff serial harness (8/8 and 12/4 widths).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_diff_serial_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // Host A: 8-bit stimulus, 8-bit result
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [7:0]  a_in_data  = 8'h00;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [7:0]  a_out_data;
    logic        a_di, a_stb, a_do, a_busy;

    // Host B: 12-bit stimulus, 4-bit result
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [11:0] b_in_data  = 12'h000;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [3:0]  b_out_data;
    logic        b_di, b_stb, b_do, b_busy;

    bram_diff_serial_host #(.DIN_N(8), .DOUT_N(8)) u_dut_a (
        .clk (clk), .rst (rst),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
        .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
        .di (a_di), .stb (a_stb), .dut_do (a_do), .busy (a_busy)
    );

    bram_diff_serial_host #(.DIN_N(12), .DOUT_N(4)) u_dut_b (
        .clk (clk), .rst (rst),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
        .di (b_di), .stb (b_stb), .dut_do (b_do), .busy (b_busy)
    );

    // Harness models: shift di in, on stb latch din and load dout for shifting
    logic [7:0]  ma_din_shr = '0, ma_din = '0, ma_dout = '0, ma_dout_shr = '0;
    logic [11:0] mb_din_shr = '0, mb_din = '0;
    logic [3:0]  mb_dout = '0, mb_dout_shr = '0;

    always @(posedge clk) begin
        if (a_stb) begin
            ma_din      <= ma_din_shr;
            ma_dout_shr <= ma_dout;
        end else begin
            ma_din_shr  <= {ma_din_shr[6:0], a_di};
            ma_dout_shr <= {ma_dout_shr[6:0], 1'b0};
        end
    end
    assign a_do = ma_dout_shr[7];

    always @(posedge clk) begin
        if (b_stb) begin
            mb_din      <= mb_din_shr;
            mb_dout_shr <= mb_dout;
        end else begin
            mb_din_shr  <= {mb_din_shr[10:0], b_di};
            mb_dout_shr <= {mb_dout_shr[2:0], 1'b0};
        end
    end
    assign b_do = mb_dout_shr[3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_din_a[$];
    logic [7:0] exp_out_a[$];
    logic [3:0] exp_out_b[$];

    int a_stb_pulses = 0;
    int a_accepts    = 0;
    int a_last_acc   = 0;
    int a_prev_acc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout got=none exp=event", name);
    endtask

    // Monitor: result handshakes of host A against the scoreboard
    initial begin : mon_out_a
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && a_out_valid && a_out_ready) begin
                if (exp_out_a.size() == 0) begin
                    fail_timeout("a_out_unexpected");
                end else begin
                    e = exp_out_a.pop_front();
                    check("a_out_data", {24'h0, a_out_data}, {24'h0, e});
                end
            end
        end
    end

    // Monitor: result handshakes of host B against the scoreboard
    initial begin : mon_out_b
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!rst && b_out_valid && b_out_ready) begin
                if (exp_out_b.size() == 0) begin
                    fail_timeout("b_out_unexpected");
                end else begin
                    e = exp_out_b.pop_front();
                    check("b_out_data", {28'h0, b_out_data}, {28'h0, e});
                end
            end
        end
    end

    // Monitor: word latched by harness A one cycle after each stb pulse
    initial begin : mon_din_a
        logic seen;
        logic [7:0] e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (seen) begin
                if (exp_din_a.size() == 0) begin
                    fail_timeout("a_stb_unexpected");
                end else begin
                    e = exp_din_a.pop_front();
                    check("a_model_din", {24'h0, ma_din}, {24'h0, e});
                end
            end
            if (a_stb && !seen) a_stb_pulses++;
            seen = a_stb;
        end
    end

    // Records the cycle of every accept on host A
    initial begin : mon_acc_a
        forever begin
            @(negedge clk);
            if (!rst && a_in_valid && a_in_ready) begin
                a_prev_acc = a_last_acc;
                a_last_acc = cyc;
                a_accepts++;
            end
        end
    end

    // Offers a word on host A and returns just after its accept edge
    task automatic a_send(input logic [7:0] d);
        bit ok;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (a_in_ready) ok = 1'b1;
        end
        if (!ok) fail_timeout("a_accept");
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [11:0] d);
        bit ok;
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (b_in_ready) ok = 1'b1;
        end
        if (!ok) fail_timeout("b_accept");
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // Waits until host A is idle with nothing outstanding on its scoreboard
    task automatic a_wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!a_busy && exp_out_a.size() == 0 && exp_din_a.size() == 0) ok = 1'b1;
        end
        if (!ok) fail_timeout(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0]  pa;
        logic [11:0] pb;
        logic        e_di;
        int          stb0, acc0;
        bit          any_stb, any_ov, ok;

        // Reset state, while rst is high and on the first cycle after it
        repeat (2) @(negedge clk);
        check("rst_high_a", {a_in_ready, a_busy, a_di, a_stb, a_out_valid, a_out_data}, 0);
        check("rst_high_b", {b_in_ready, b_busy, b_di, b_stb, b_out_valid, b_out_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_a", {a_in_ready, a_busy, a_di, a_stb, a_out_valid, a_out_data}, 13'h1000);
        check("rst_release_b", {b_in_ready, b_busy, b_di, b_stb, b_out_valid, b_out_data}, 9'h100);

        // Test 1: A5 out, 3C back, cycle-accurate di/stb/out_valid
        ma_dout     = 8'h3C;
        a_out_ready = 1'b1;
        exp_din_a.push_back(8'hA5);
        exp_out_a.push_back(8'h3C);
        pa = 8'hA5;
        a_send(8'hA5);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            e_di = (k <= 8) ? pa[8-k] : 1'b0;
            check($sformatf("t1_cyc%0d_di_stb_ov", k), {a_di, a_stb, a_out_valid},
                  {e_di, (k == 9), 1'b0});
            if (k == 10) check("t1_model_din", {24'h0, ma_din}, 32'hA5);
        end
        @(negedge clk);
        check("t1_out_valid_latency", {a_out_valid, a_out_data}, 9'h13C);
        a_wait_idle("t1_idle");

        // Test 2: back-to-back words with in_valid held high
        ma_dout = 8'h81;
        stb0    = a_stb_pulses;
        exp_din_a.push_back(8'h01);
        exp_out_a.push_back(8'h81);
        exp_din_a.push_back(8'hFE);
        exp_out_a.push_back(8'h81);
        a_send(8'h01);
        a_in_valid = 1'b1;
        a_in_data  = 8'hFE;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (a_in_ready) ok = 1'b1;
        end
        if (!ok) fail_timeout("t2_second_accept");
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("t2_accept_spacing", a_last_acc - a_prev_acc, 19);
        a_wait_idle("t2_idle");
        check("t2_stb_pulses", a_stb_pulses - stb0, 2);

        // Test 3: consumer stalls for 10 cycles
        ma_dout     = 8'hC3;
        a_out_ready = 1'b0;
        exp_din_a.push_back(8'h77);
        exp_out_a.push_back(8'hC3);
        a_send(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (a_out_valid) ok = 1'b1;
        end
        if (!ok) fail_timeout("t3_out_valid");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_hold%0d", i), {a_out_valid, a_out_data, a_in_ready}, 10'h386);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_in_ready_back", {a_in_ready, a_busy, a_out_valid}, 3'b100);

        // Test 4: reset during SHIFT cycle 4 aborts the transaction
        ma_dout = 8'h11;
        stb0    = a_stb_pulses;
        a_send(8'hFF);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_after_rst", {a_di, a_stb, a_out_valid, a_busy, a_in_ready, a_out_data}, 13'h100);
        any_stb = 1'b0;
        any_ov  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_stb) any_stb = 1'b1;
            if (a_out_valid) any_ov = 1'b1;
        end
        check("t4_no_stb_after_rst", {any_stb, a_stb_pulses - stb0}, 0);
        check("t4_no_partial_valid", any_ov, 0);
        ma_dout = 8'hE7;
        exp_din_a.push_back(8'h5A);
        exp_out_a.push_back(8'hE7);
        a_send(8'h5A);
        a_wait_idle("t4_idle");

        // Test 5: 12-bit stimulus, 4-bit result
        mb_dout     = 4'h9;
        b_out_ready = 1'b1;
        exp_out_b.push_back(4'h9);
        pb = 12'hABC;
        b_send(12'hABC);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            e_di = (k <= 12) ? pb[12-k] : 1'b0;
            check($sformatf("t5_cyc%0d_di_stb_ov", k), {b_di, b_stb, b_out_valid},
                  {e_di, (k == 13), 1'b0});
            if (k == 14) check("t5_model_din", {20'h0, mb_din}, 32'hABC);
        end
        @(negedge clk);
        check("t5_out_valid_latency", {b_out_valid, b_out_data}, 5'h19);
        @(negedge clk);
        check("t5_sb_empty", exp_out_b.size(), 0);

        // Test 6: in_valid and in_data activity during CAPTURE is ignored
        ma_dout = 8'h5A;
        exp_din_a.push_back(8'h96);
        exp_out_a.push_back(8'h5A);
        a_send(8'h96);
        acc0 = a_accepts;
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_data  = 8'hFF;
        for (int k = 10; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("t6_cyc%0d_ready_di_stb", k), {a_in_ready, a_di, a_stb}, 0);
            @(posedge clk); #1;
            if (k == 17) a_in_valid = 1'b0;
            else         a_in_data  = ~a_in_data;
        end
        a_wait_idle("t6_idle");
        check("t6_no_extra_accept", a_accepts - acc0, 0);

        check("final_sb_empty", exp_din_a.size() + exp_out_a.size() + exp_out_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
